stall_ctrl: RTL and testbench
=============================

Name: stall_ctrl

Overview:
- Producer side of the per-stage stall handshake consumed by the pipeline registers (pc_reg, if_id, id_ex, ex_mem, mem_wb).
- Also arbitrates the single memory port between IF fetches and MEM loads/stores.
- Generates hold/flush signals for the 5-stage RV32I pipeline from three sources: memory wait, load-use hazard, EX jump.
- Semantics: a stage register with stall=1 holds its contents and drives its own *_rdy low, so the next stage sees a bubble.

Parameters:
- PERF_W, 32, width of optional performance counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global ready; low freezes all internal state
- if_req  in  1  IF requests an instruction fetch
- if_done  in  1  memory port returns fetch data this cycle
- mem_req  in  1  MEM stage has a valid load/store
- mem_done  in  1  memory port completes load/store this cycle
- id_load_use  in  1  ID source register equals rd of a load currently in EX
- id_ex_rdy  in  1  EX holds a valid instruction
- ex_jump  in  1  EX resolved a taken branch/jump
- if_grant  out  1  memory port owned by IF
- mem_grant  out  1  memory port owned by MEM
- fetch_drop  out  1  discard the fetch word returning this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- id_ex_stall  out  1  hold ID/EX
- ex_mem_stall  out  1  hold EX/MEM
- mem_wb_stall  out  1  hold MEM/WB
- if_id_flush  out  1  IF/ID loads NOP next edge
- id_ex_flush  out  1  ID/EX loads NOP next edge
- perf_mem_stall  out  PERF_W  cycles spent in MEM_WAIT
- perf_bubble  out  PERF_W  load-use bubbles inserted
- perf_flush  out  PERF_W  flushes issued

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All grants, stalls, flushes and fetch_drop = 0.
  - Counters = 0.
  - Reset mid-transaction abandons it; no completion is expected after release.
- FSM (advances only when rdy=1):
  - IDLE: mem_req -> MEM_WAIT. Else if_req -> IF_WAIT. MEM has priority on the same cycle.
  - IF_WAIT: if_done -> MEM_WAIT if mem_req, else IF_WAIT if if_req, else IDLE. An in-flight fetch is never aborted.
  - MEM_WAIT: mem_done -> IF_WAIT if if_req, else IDLE.
- Grants are registered: if_grant = (state==IF_WAIT), mem_grant = (state==MEM_WAIT). The first access cycle is one edge after the request.
- Stall outputs are combinational from state and inputs:
  - mem_hold = mem_req && !(state==MEM_WAIT && mem_done).
  - When mem_hold: pc, if_id, id_ex and ex_mem stalls = 1; mem_wb_stall = 1 (WB sees a bubble).
  - fetch_wait = if_req && !(state==IF_WAIT && if_done). When fetch_wait and not mem_hold: pc_stall = if_id_stall = 1 only.
- Load-use (id_load_use && id_ex_rdy && !mem_hold): pc_stall, if_id_stall, id_ex_stall = 1 for exactly one cycle, giving one bubble into EX.
- Jump (ex_jump && id_ex_rdy && !mem_hold):
  - if_id_flush = id_ex_flush = 1.
  - Load-use stall is suppressed; flush has priority.
  - pc is not stalled, so the target loads.
  - Under mem_hold, EX is held; the flush fires on the first cycle EX advances.
- Jump while state==IF_WAIT and !if_done: a drop flag is set. fetch_drop = 1 on the cycle if_done returns, then the flag clears. Jump coincident with if_done gives fetch_drop = 1 that cycle.
- rdy=0: all stall outputs = 1, flushes = 0, state and counters frozen.

Optional Feature:
- STALL_PERF_EN defined: three saturating PERF_W counters.
  - perf_mem_stall increments when mem_hold && rdy.
  - perf_bubble increments per load-use bubble.
  - perf_flush increments per flush cycle.
- Undefined: the perf_* ports exist but are tied to 0; no counter flops.

Decomposition:
- Shared config.v: True/False, ZERO_WORD, arbiter state encodings (ARB_IDLE/ARB_IF/ARB_MEM, 2 bits).
- Sub-module mem_port_arb: the FSM, grants and drop flag.
- stall_ctrl top: stall/flush combinational logic and the optional counters.

Test Plan:
- if_req and mem_req both rise from IDLE -> mem_grant=1 next cycle, all stalls 1 until mem_done, then if_grant=1 the following cycle.
- mem_req during IF_WAIT with if_done 3 cycles later -> if_grant held 3 cycles, mem_grant asserted the cycle after if_done.
- id_load_use=1, id_ex_rdy=1 for 2 cycles (second cycle from the held instruction deasserted by ID) -> exactly one cycle of pc/if_id/id_ex stall; perf_bubble=1.
- ex_jump=1 with id_load_use=1 in the same cycle -> both flushes=1, pc_stall=0, id_ex_stall=0; perf_flush=1.
- ex_jump in IF_WAIT, if_done 2 cycles later -> fetch_drop=1 on exactly that cycle, 0 after.
- rst_n pulled low in MEM_WAIT -> all outputs 0 asynchronously; after release with no requests, state stays IDLE and mem_grant=0.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stall_ctrl_pkg
// Description : Shared constants and types for the pipeline stall controller
//               and its memory-port arbiter: boolean constants, a zero word,
//               arbiter state encodings and the per-stage stall vector.
// Revision    : 1.0 - initial release
// ============================================================================
package stall_ctrl_pkg;

  localparam logic        TRUE      = 1'b1;
  localparam logic        FALSE     = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Arbiter state encodings (2 bits)
  localparam int ARB_W = 2;
  typedef logic [ARB_W-1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_IF   = 2'd1;
  localparam arb_state_t ARB_MEM  = 2'd2;

  // One hold bit per pipeline register, front of the pipe first
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stall_vec_t;

  localparam stall_vec_t STALL_NONE = 5'b00000;
  localparam stall_vec_t STALL_ALL  = 5'b11111;

endpackage : stall_ctrl_pkg
`default_nettype wire

// File: rtl/stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : stall_ctrl_if
// Description : Bundle between the 5-stage pipeline / memory port and the
//               stall controller.
//   master : pipeline side; drives rdy, request/done and hazard inputs,
//            receives grants, stalls, flushes, fetch_drop and perf counters.
//   slave  : stall controller side (mirror image).
// Revision    : 1.0 - initial release
// ============================================================================
interface stall_ctrl_if #(
  parameter int PERF_W = 32
) ();

  // Pipeline -> controller
  logic rdy;
  logic if_req;
  logic if_done;
  logic mem_req;
  logic mem_done;
  logic id_load_use;
  logic id_ex_rdy;
  logic ex_jump;

  // Controller -> pipeline
  logic if_grant;
  logic mem_grant;
  logic fetch_drop;
  logic pc_stall;
  logic if_id_stall;
  logic id_ex_stall;
  logic ex_mem_stall;
  logic mem_wb_stall;
  logic if_id_flush;
  logic id_ex_flush;
  logic [PERF_W-1:0] perf_mem_stall;
  logic [PERF_W-1:0] perf_bubble;
  logic [PERF_W-1:0] perf_flush;

  modport master (
    output rdy, if_req, if_done, mem_req, mem_done,
           id_load_use, id_ex_rdy, ex_jump,
    input  if_grant, mem_grant, fetch_drop,
           pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush,
           perf_mem_stall, perf_bubble, perf_flush
  );

  modport slave (
    input  rdy, if_req, if_done, mem_req, mem_done,
           id_load_use, id_ex_rdy, ex_jump,
    output if_grant, mem_grant, fetch_drop,
           pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush,
           perf_mem_stall, perf_bubble, perf_flush
  );

endinterface : stall_ctrl_if
`default_nettype wire

// File: rtl/stall_ctrl_mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : stall_ctrl_mem_port_arb
// Description : Arbiter for the single memory port shared by IF fetches and
//               MEM loads/stores. MEM wins when both start together; an
//               in-flight access always runs to completion. Also tracks a
//               fetch that was made stale by a redirect so its returning
//               word can be discarded.
// Ports       :
//   clk, rst_n   clock, asynchronous active-low reset
//   rdy          global ready; low freezes all state
//   if_req/done  fetch request / fetch data returning this cycle
//   mem_req/done load-store request / load-store completing this cycle
//   jump_flush   redirect being taken this cycle (already qualified)
//   state        current arbiter state
//   if_grant     port owned by IF
//   mem_grant    port owned by MEM
//   fetch_drop   discard the fetch word returning this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module stall_ctrl_mem_port_arb
  import stall_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       if_req,
  input  logic       if_done,
  input  logic       mem_req,
  input  logic       mem_done,
  input  logic       jump_flush,
  output arb_state_t state,
  output logic       if_grant,
  output logic       mem_grant,
  output logic       fetch_drop
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_drop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (mem_req)     w_state_nxt = ARB_MEM;
        else if (if_req) w_state_nxt = ARB_IF;
      end
      ARB_IF: begin
        if (if_done) begin
          if (mem_req)     w_state_nxt = ARB_MEM;
          else if (if_req) w_state_nxt = ARB_IF;
          else             w_state_nxt = ARB_IDLE;
        end
      end
      ARB_MEM: begin
        if (mem_done) begin
          if (if_req) w_state_nxt = ARB_IF;
          else        w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Output decode: grants come straight from the state flops
  always_comb begin
    state      = r_state;
    if_grant   = (r_state == ARB_IF);
    mem_grant  = (r_state == ARB_MEM);
    // A redirect taken on the returning cycle also makes that word stale
    fetch_drop = rdy && (r_state == ARB_IF) && if_done && (r_drop || jump_flush);
  end

  // Remembers a redirect that happened while a fetch was still outstanding;
  // cleared as soon as that fetch returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= FALSE;
    end else if (rdy && (r_state == ARB_IF)) begin
      if (if_done)         r_drop <= FALSE;
      else if (jump_flush) r_drop <= TRUE;
    end
  end

endmodule : stall_ctrl_mem_port_arb
`default_nettype wire

// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stall_ctrl
// Description : Hold/flush generator for the 5-stage RV32I pipeline. Combines
//               memory wait, load-use hazard and EX redirect into per-stage
//               stall and flush strobes, and owns the memory-port arbiter.
//               A stalled stage register keeps its contents and presents a
//               bubble downstream.
// Config      : `define STALL_PERF_EN to build three saturating performance
//               counters; otherwise the perf_* outputs are constant zero.
// Ports       :
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    stall_ctrl_if.slave (requests, hazards, grants, stalls, flushes,
//          fetch_drop, perf counters)
// Revision    : 1.0 - initial release
// ============================================================================
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  stall_ctrl_if.slave  bus
);

  arb_state_t w_state;
  logic       w_mem_hold;
  logic       w_fetch_wait;
  logic       w_jump;
  logic       w_lu_cond;
  logic       w_load_use;
  logic       w_flush;
  logic       r_lu_issued;
  stall_vec_t w_stall;

  stall_ctrl_mem_port_arb u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (bus.rdy),
    .if_req     (bus.if_req),
    .if_done    (bus.if_done),
    .mem_req    (bus.mem_req),
    .mem_done   (bus.mem_done),
    .jump_flush (w_flush),
    .state      (w_state),
    .if_grant   (bus.if_grant),
    .mem_grant  (bus.mem_grant),
    .fetch_drop (bus.fetch_drop)
  );

  // Hazard sources. The back of the pipe is frozen while a load/store waits,
  // so a jump in EX is only acted on once EX can advance.
  always_comb begin
    w_mem_hold   = bus.mem_req && !((w_state == ARB_MEM) && bus.mem_done);
    w_fetch_wait = bus.if_req  && !((w_state == ARB_IF)  && bus.if_done);
    w_jump       = bus.ex_jump && bus.id_ex_rdy && !w_mem_hold;
    w_lu_cond    = bus.id_load_use && bus.id_ex_rdy;
    // Only one bubble per hazard: once issued, the still-asserted condition
    // from the held instruction is ignored. A redirect wins over the bubble.
    w_load_use   = w_lu_cond && !w_mem_hold && !w_jump && !r_lu_issued;
    w_flush      = rst_n && bus.rdy && w_jump;
  end

  // Stays set while the hazard that already produced its bubble persists
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_issued <= FALSE;
    end else if (bus.rdy) begin
      r_lu_issued <= w_lu_cond && (r_lu_issued || w_load_use);
    end
  end

  // Per-stage holds. Outputs are forced low while reset is asserted so the
  // pipeline sees a quiet controller regardless of its inputs.
  always_comb begin
    w_stall = STALL_NONE;
    if (!rst_n) begin
      w_stall = STALL_NONE;
    end else if (!bus.rdy || w_mem_hold) begin
      w_stall = STALL_ALL;
    end else begin
      // On a redirect the PC must load the target, so fetch waits do not hold it
      w_stall.pc    = !w_jump && (w_fetch_wait || w_load_use);
      w_stall.if_id = !w_jump && (w_fetch_wait || w_load_use);
      w_stall.id_ex = w_load_use;
    end
  end

  assign bus.pc_stall     = w_stall.pc;
  assign bus.if_id_stall  = w_stall.if_id;
  assign bus.id_ex_stall  = w_stall.id_ex;
  assign bus.ex_mem_stall = w_stall.ex_mem;
  assign bus.mem_wb_stall = w_stall.mem_wb;
  assign bus.if_id_flush  = w_flush;
  assign bus.id_ex_flush  = w_flush;

`ifdef STALL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] r_perf_mem_stall;
  logic [PERF_W-1:0] r_perf_bubble;
  logic [PERF_W-1:0] r_perf_flush;

  // Saturating event counters, frozen together with the rest of the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_mem_stall <= '0;
      r_perf_bubble    <= '0;
      r_perf_flush     <= '0;
    end else if (bus.rdy) begin
      if (w_mem_hold && (r_perf_mem_stall != '1))
        r_perf_mem_stall <= r_perf_mem_stall + PERF_ONE;
      if (w_load_use && (r_perf_bubble != '1))
        r_perf_bubble <= r_perf_bubble + PERF_ONE;
      if (w_jump && (r_perf_flush != '1))
        r_perf_flush <= r_perf_flush + PERF_ONE;
    end
  end

  assign bus.perf_mem_stall = r_perf_mem_stall;
  assign bus.perf_bubble    = r_perf_bubble;
  assign bus.perf_flush     = r_perf_flush;
`else
  assign bus.perf_mem_stall = {PERF_W{1'b0}};
  assign bus.perf_bubble    = {PERF_W{1'b0}};
  assign bus.perf_flush     = {PERF_W{1'b0}};
`endif

endmodule : stall_ctrl
`default_nettype wire

// File: tb/tb_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stall_ctrl
// Description : Self-checking bench for stall_ctrl: a directed vector table,
//               hand-written multi-cycle sequences (arbitration, async reset,
//               load-use/redirect counters) and a randomized run compared
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stall_ctrl;

  localparam int PERF_W = 32;
`ifdef STALL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stall_ctrl_if #(.PERF_W(PERF_W)) bus ();
  stall_ctrl #(.PERF_W(PERF_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // {if_grant, mem_grant, fetch_drop, pc, if_id, id_ex, ex_mem, mem_wb stalls,
  //  if_id_flush, id_ex_flush}
  logic [9:0]          obs;
  logic [3*PERF_W-1:0] perf_obs;
  assign obs = {bus.if_grant, bus.mem_grant, bus.fetch_drop,
                bus.pc_stall, bus.if_id_stall, bus.id_ex_stall,
                bus.ex_mem_stall, bus.mem_wb_stall,
                bus.if_id_flush, bus.id_ex_flush};
  assign perf_obs = {bus.perf_mem_stall, bus.perf_bubble, bus.perf_flush};

  // Input vector: {rdy, if_req, if_done, mem_req, mem_done, id_load_use, id_ex_rdy, ex_jump}
  typedef struct {
    logic [7:0] in;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl [15];

  task automatic drive(input logic [7:0] v);
    {bus.rdy, bus.if_req, bus.if_done, bus.mem_req, bus.mem_done,
     bus.id_load_use, bus.id_ex_rdy, bus.ex_jump} = v;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    drive(8'h00);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // ---------------- directed table, starting from IDLE ----------------
    tbl[0]  = '{8'b1101_0000, 10'b000_11111_00}; // if+mem rise in IDLE
    tbl[1]  = '{8'b1101_0000, 10'b010_11111_00}; // MEM granted, waiting
    tbl[2]  = '{8'b1101_1000, 10'b010_11000_00}; // mem_done, fetch still waits
    tbl[3]  = '{8'b1100_0000, 10'b100_11000_00}; // IF granted
    tbl[4]  = '{8'b1100_0011, 10'b100_00000_11}; // jump mid-fetch
    tbl[5]  = '{8'b1100_0000, 10'b100_11000_00};
    tbl[6]  = '{8'b1110_0000, 10'b101_00000_00}; // stale word dropped
    tbl[7]  = '{8'b1000_0110, 10'b100_11100_00}; // load-use bubble
    tbl[8]  = '{8'b1000_0110, 10'b100_00000_00}; // held instr: no 2nd bubble
    tbl[9]  = '{8'b0101_0000, 10'b100_11111_00}; // rdy low: freeze
    tbl[10] = '{8'b1011_0011, 10'b100_11111_00}; // jump blocked by mem_hold
    tbl[11] = '{8'b1001_1011, 10'b010_00000_11}; // EX advances: flush fires
    tbl[12] = '{8'b1000_0000, 10'b000_00000_00}; // idle
    tbl[13] = '{8'b1000_0111, 10'b000_00000_11}; // jump beats load-use
    tbl[14] = '{8'b1000_0110, 10'b000_11100_00};

    // Reset state with requests already asserted
    drive(8'b1101_0111);
    #1;
    chk("reset_outputs", {obs, perf_obs}, '0);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].in);
      #1;
      chk($sformatf("vec%0d", i), obs, tbl[i].exp);
    end

    // ---------------- mem_req while a fetch is in flight ----------------
    @(negedge clk);
    drive(8'b1100_0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive((k == 2) ? 8'b1111_0000 : 8'b1101_0000);
      #1;
      chk("if_held_grant", {bus.if_grant, bus.mem_grant}, 2'b10);
    end
    @(negedge clk);
    drive(8'b1001_0000);
    #1;
    chk("mem_after_fetch", {bus.if_grant, bus.mem_grant}, 2'b01);

    // ---------------- async reset in MEM_WAIT ----------------
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {obs, perf_obs}, '0);
    @(negedge clk);
    drive(8'b1000_0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_reset_idle", obs, '0);

    // ---------------- one bubble, then redirect; counters ----------------
    @(negedge clk);
    drive(8'b1000_0110);
    #1 chk("lu_first", obs, 10'b000_11100_00);
    @(negedge clk);
    #1 chk("lu_second", obs, 10'b000_00000_00);
    @(negedge clk);
    drive(8'b1000_0111);
    #1 chk("jump_lu", obs, 10'b000_00000_11);
    @(negedge clk);
    drive(8'b1000_0000);
    #1 chk("perf_counts", perf_obs,
           {{PERF_W{1'b0}}, PERF_W'(PERF_ON), PERF_W'(PERF_ON)});

    // ---------------- randomized run against reference model ----------------
    do_reset();
    begin : rand_phase
      int owner;                  // 0 none, 1 fetch, 2 load/store
      bit drop_pend, bubble_given;
      logic [PERF_W-1:0] c_ms, c_bub, c_fl;
      bit rdy_r, ifr, ifd, mr, md, lu, ider, jmp;
      bit mem_busy, fetch_busy, take_jump, hazard, take_bubble, front, finished;
      logic [9:0] e;
      owner = 0; drop_pend = 0; bubble_given = 0;
      c_ms = '0; c_bub = '0; c_fl = '0;
      for (int n = 0; n < 600; n++) begin
        @(negedge clk);
        rdy_r = ($urandom_range(0, 7) != 0);
        ifr   = ($urandom_range(0, 3) != 0);
        ifd   = ($urandom_range(0, 2) == 0);
        mr    = ($urandom_range(0, 2) == 0);
        md    = ($urandom_range(0, 2) == 0);
        lu    = ($urandom_range(0, 3) == 0);
        ider  = ($urandom_range(0, 1) == 1);
        jmp   = ($urandom_range(0, 5) == 0);
        drive({rdy_r, ifr, ifd, mr, md, lu, ider, jmp});
        #1;
        mem_busy    = mr && !(owner == 2 && md);
        fetch_busy  = ifr && !(owner == 1 && ifd);
        take_jump   = jmp && ider && !mem_busy;
        hazard      = lu && ider;
        take_bubble = hazard && !mem_busy && !take_jump && !bubble_given;
        e = '0;
        e[9] = (owner == 1);
        e[8] = (owner == 2);
        e[7] = rdy_r && (owner == 1) && ifd && (drop_pend || take_jump);
        if (!rdy_r || mem_busy) begin
          e[6:2] = 5'b11111;
        end else begin
          front = !take_jump && (fetch_busy || take_bubble);
          e[6] = front;
          e[5] = front;
          e[4] = take_bubble;
          e[1] = take_jump;
          e[0] = take_jump;
        end
        chk("rand_outputs", obs, e);
        chk("rand_perf", perf_obs,
            PERF_ON ? {c_ms, c_bub, c_fl} : {3*PERF_W{1'b0}});
        if (rdy_r) begin
          if (mem_busy    && c_ms  != '1) c_ms  = c_ms  + 1'b1;
          if (take_bubble && c_bub != '1) c_bub = c_bub + 1'b1;
          if (take_jump   && c_fl  != '1) c_fl  = c_fl  + 1'b1;
          if (owner == 1) begin
            if (ifd)            drop_pend = 0;
            else if (take_jump) drop_pend = 1;
          end
          bubble_given = hazard && (bubble_given || take_bubble);
          // Port is re-assigned whenever it is free or its access completes;
          // a finishing load/store never immediately wins the port again.
          finished = (owner == 0) || (owner == 1 && ifd) || (owner == 2 && md);
          if (finished) owner = (mr && owner != 2) ? 2 : (ifr ? 1 : 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stall_ctrl
`default_nettype wire
